// File: rtl/albacore_control.sv
// Multicycle control FSM for the albacore CPU: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable. Outputs are registered copies of the next-state decode.
module albacore_control #(
  parameter logic [3:0] ALU_ADDR    = 4'h8,
  parameter logic [3:0] ALU_BR      = 4'hA,
  parameter logic [3:0] ALU_INC_PC  = 4'hB,
  parameter logic [3:0] ALU_PASS_PC = 4'hD,
  parameter logic [3:0] ALU_PASS_A  = 4'hE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       neg,
  output logic       s_addr,
  output logic       en_inst,
  output logic       en_a,
  output logic       en_b,
  output logic       en_f,
  output logic       en_mdr,
  output logic       en_pc,
  output logic [3:0] alu_op,
  output logic       s_regfile_din,
  output logic       we_regfile,
  output logic       s_regfile_rw,
  output logic       mem_we,
  output logic       halted,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_START   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_WB_ALU  = 4'd4,
    S_MEM_RD  = 4'd5,
    S_WB_MEM  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BR_TAKE = 4'd8,
    S_WB_LINK = 4'd9,
    S_HALT    = 4'd10
  } state_t;

  typedef struct packed {
    logic       s_addr;
    logic       en_inst;
    logic       en_a;
    logic       en_b;
    logic       en_f;
    logic       en_mdr;
    logic       en_pc;
    logic [3:0] alu_op;
    logic       s_regfile_din;
    logic       we_regfile;
    logic       s_regfile_rw;
    logic       mem_we;
    logic       halted;
  } ctrl_t;

  state_t state_q;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   take;
  logic   flag;

  // Branch condition for BZ/BN, sampled while in EXEC.
  assign flag = (opcode == 4'hB) ? zero : neg;

  function automatic state_t next_of(input state_t s, input logic [3:0] op, input logic f,
                                     input logic tk);
    state_t n;
    n = S_START;
    case (s)
      S_START:   n = S_FETCH;
      S_FETCH:   n = S_DECODE;
      S_DECODE:  n = S_EXEC;
      S_EXEC: begin
        case (op)
          4'h8:         n = S_MEM_RD;
          4'h9:         n = S_MEM_WR;
          4'hA, 4'hE:   n = S_FETCH;
          4'hB, 4'hC:   n = f ? S_BR_TAKE : S_FETCH;
          4'hD:         n = S_WB_LINK;
          4'hF:         n = S_HALT;
          default:      n = S_WB_ALU;
        endcase
      end
      S_WB_ALU:  n = S_FETCH;
      S_MEM_RD:  n = S_WB_MEM;
      S_WB_MEM:  n = S_FETCH;
      S_MEM_WR:  n = S_FETCH;
      // take is always set on entry; a clear flag here can only mean corrupted state.
      S_BR_TAKE: n = tk ? S_FETCH : S_START;
      S_WB_LINK: n = S_FETCH;
      S_HALT:    n = S_HALT;
      default:   n = S_START;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.en_inst = 1'b1;
        c.en_pc   = 1'b1;
        c.alu_op  = ALU_INC_PC;
      end
      S_DECODE: begin
        c.en_a = 1'b1;
        c.en_b = 1'b1;
      end
      S_EXEC: begin
        case (op)
          4'h8, 4'h9: begin
            c.alu_op = ALU_ADDR;
            c.en_f   = 1'b1;
          end
          4'hA: begin
            c.alu_op = ALU_BR;
            c.en_pc  = 1'b1;
          end
          4'hB, 4'hC: c.alu_op = ALU_PASS_A;
          4'hD: begin
            c.alu_op = ALU_PASS_PC;
            c.en_f   = 1'b1;
          end
          4'hE: begin
            c.alu_op = ALU_PASS_A;
            c.en_pc  = 1'b1;
          end
          4'hF: c = '0;
          default: begin
            c.alu_op = op;
            c.en_f   = 1'b1;
          end
        endcase
      end
      S_WB_ALU: c.we_regfile = 1'b1;
      S_MEM_RD: begin
        c.s_addr = 1'b1;
        c.en_mdr = 1'b1;
      end
      S_WB_MEM: begin
        c.we_regfile    = 1'b1;
        c.s_regfile_din = 1'b1;
      end
      S_MEM_WR: begin
        c.s_addr = 1'b1;
        c.mem_we = 1'b1;
      end
      S_BR_TAKE: begin
        c.alu_op = ALU_BR;
        c.en_pc  = 1'b1;
      end
      S_WB_LINK: begin
        c.we_regfile   = 1'b1;
        c.s_regfile_rw = 1'b1;
        c.alu_op       = ALU_BR;
        c.en_pc        = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign nxt = next_of(state_q, opcode, flag, take);

  // State, branch flag and the registered output decode of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      take    <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= nxt;
      ctrl_q  <= decode(nxt, opcode);
      if (state_q == S_EXEC && (opcode == 4'hB || opcode == 4'hC)) begin
        take <= flag;
      end
    end
  end

  assign s_addr        = ctrl_q.s_addr;
  assign en_inst       = ctrl_q.en_inst;
  assign en_a          = ctrl_q.en_a;
  assign en_b          = ctrl_q.en_b;
  assign en_f          = ctrl_q.en_f;
  assign en_mdr        = ctrl_q.en_mdr;
  assign en_pc         = ctrl_q.en_pc;
  assign alu_op        = ctrl_q.alu_op;
  assign s_regfile_din = ctrl_q.s_regfile_din;
  assign we_regfile    = ctrl_q.we_regfile;
  assign s_regfile_rw  = ctrl_q.s_regfile_rw;
  assign mem_we        = ctrl_q.mem_we;
  assign halted        = ctrl_q.halted;
  assign state         = state_q;

endmodule

// File: tb/tb_albacore_control.sv
// Directed self-checking bench for albacore_control: walks every instruction class, reset and HALT.
module tb_albacore_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       neg;
  logic       s_addr, en_inst, en_a, en_b, en_f, en_mdr, en_pc;
  logic [3:0] alu_op;
  logic       s_regfile_din, we_regfile, s_regfile_rw, mem_we, halted;
  logic [3:0] state;
  logic [15:0] outs;

  int n_checks = 0;
  int n_pass   = 0;

  albacore_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .neg(neg),
    .s_addr(s_addr), .en_inst(en_inst), .en_a(en_a), .en_b(en_b), .en_f(en_f),
    .en_mdr(en_mdr), .en_pc(en_pc), .alu_op(alu_op), .s_regfile_din(s_regfile_din),
    .we_regfile(we_regfile), .s_regfile_rw(s_regfile_rw), .mem_we(mem_we),
    .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bits: s_addr en_inst en_a en_b en_f en_mdr en_pc alu_op[3:0] din we rw mem_we halted
  assign outs = {s_addr, en_inst, en_a, en_b, en_f, en_mdr, en_pc, alu_op,
                 s_regfile_din, we_regfile, s_regfile_rw, mem_we, halted};

  localparam logic [15:0] O_ZERO    = 16'h0000;
  localparam logic [15:0] O_FETCH   = 16'h4360;
  localparam logic [15:0] O_DECODE  = 16'h3000;
  localparam logic [15:0] O_WB_ALU  = 16'h0008;
  localparam logic [15:0] O_EX_LDST = 16'h0900;
  localparam logic [15:0] O_MEM_RD  = 16'h8400;
  localparam logic [15:0] O_WB_MEM  = 16'h0018;
  localparam logic [15:0] O_MEM_WR  = 16'h8002;
  localparam logic [15:0] O_BR      = 16'h0340;
  localparam logic [15:0] O_EX_BC   = 16'h01C0;
  localparam logic [15:0] O_EX_JAL  = 16'h09A0;
  localparam logic [15:0] O_WB_LINK = 16'h034C;
  localparam logic [15:0] O_EX_JR   = 16'h03C0;
  localparam logic [15:0] O_HALT    = 16'h0001;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input string tag, input logic [3:0] exp_state, input logic [15:0] exp_outs);
    @(posedge clk);
    #2;
    check({tag, ".state"}, 16'(state), 16'(exp_state));
    check({tag, ".outs"}, outs, exp_outs);
  endtask

  task automatic start_instr(input logic [3:0] op, input logic z, input logic n);
    opcode = op;
    zero   = z;
    neg    = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    opcode = 4'h0;
    zero   = 1'b0;
    neg    = 1'b0;
    #12;
    check("reset.state", 16'(state), 16'h0);
    check("reset.outs", outs, O_ZERO);
    rst_n = 1'b1;
    step("start_fetch", 4'd1, O_FETCH);

    start_instr(4'h0, 1'b0, 1'b0);
    step("add.dec", 4'd2, O_DECODE);
    step("add.exec", 4'd3, 16'h0800);
    step("add.wb", 4'd4, O_WB_ALU);
    step("add.fetch", 4'd1, O_FETCH);

    start_instr(4'h1, 1'b1, 1'b1);
    step("sub.dec", 4'd2, O_DECODE);
    step("sub.exec", 4'd3, 16'h0820);
    step("sub.wb", 4'd4, O_WB_ALU);
    step("sub.fetch", 4'd1, O_FETCH);

    start_instr(4'h7, 1'b0, 1'b0);
    step("ldi.dec", 4'd2, O_DECODE);
    step("ldi.exec", 4'd3, 16'h08E0);
    step("ldi.wb", 4'd4, O_WB_ALU);
    step("ldi.fetch", 4'd1, O_FETCH);

    start_instr(4'h8, 1'b0, 1'b0);
    step("ld.dec", 4'd2, O_DECODE);
    step("ld.exec", 4'd3, O_EX_LDST);
    step("ld.memrd", 4'd5, O_MEM_RD);
    step("ld.wbmem", 4'd6, O_WB_MEM);
    step("ld.fetch", 4'd1, O_FETCH);

    start_instr(4'h9, 1'b0, 1'b0);
    step("st.dec", 4'd2, O_DECODE);
    step("st.exec", 4'd3, O_EX_LDST);
    step("st.memwr", 4'd7, O_MEM_WR);
    step("st.fetch", 4'd1, O_FETCH);

    start_instr(4'hA, 1'b0, 1'b0);
    step("br.dec", 4'd2, O_DECODE);
    step("br.exec", 4'd3, O_BR);
    step("br.fetch", 4'd1, O_FETCH);

    start_instr(4'hB, 1'b1, 1'b0);
    step("bz_t.dec", 4'd2, O_DECODE);
    step("bz_t.exec", 4'd3, O_EX_BC);
    step("bz_t.take", 4'd8, O_BR);
    step("bz_t.fetch", 4'd1, O_FETCH);

    start_instr(4'hB, 1'b0, 1'b1);
    step("bz_n.dec", 4'd2, O_DECODE);
    step("bz_n.exec", 4'd3, O_EX_BC);
    step("bz_n.fetch", 4'd1, O_FETCH);

    start_instr(4'hC, 1'b0, 1'b1);
    step("bn_t.dec", 4'd2, O_DECODE);
    step("bn_t.exec", 4'd3, O_EX_BC);
    step("bn_t.take", 4'd8, O_BR);
    step("bn_t.fetch", 4'd1, O_FETCH);

    start_instr(4'hC, 1'b1, 1'b0);
    step("bn_n.dec", 4'd2, O_DECODE);
    step("bn_n.exec", 4'd3, O_EX_BC);
    step("bn_n.fetch", 4'd1, O_FETCH);

    start_instr(4'hD, 1'b0, 1'b0);
    step("jal.dec", 4'd2, O_DECODE);
    step("jal.exec", 4'd3, O_EX_JAL);
    step("jal.link", 4'd9, O_WB_LINK);
    step("jal.fetch", 4'd1, O_FETCH);

    start_instr(4'hE, 1'b0, 1'b0);
    step("jr.dec", 4'd2, O_DECODE);
    step("jr.exec", 4'd3, O_EX_JR);
    step("jr.fetch", 4'd1, O_FETCH);

    // Asynchronous reset in the middle of an ADD's EXEC cycle.
    start_instr(4'h0, 1'b0, 1'b0);
    step("rst_add.dec", 4'd2, O_DECODE);
    step("rst_add.exec", 4'd3, 16'h0800);
    rst_n = 1'b0;
    #1;
    check("rst_mid.state", 16'(state), 16'h0);
    check("rst_mid.outs", outs, O_ZERO);
    step("rst_hold", 4'd0, O_ZERO);
    rst_n = 1'b1;
    step("rst_rel.fetch", 4'd1, O_FETCH);

    start_instr(4'hF, 1'b0, 1'b0);
    step("quit.dec", 4'd2, O_DECODE);
    step("quit.exec", 4'd3, O_ZERO);
    step("quit.halt", 4'd10, O_HALT);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      zero   = 1'($urandom_range(0, 1));
      neg    = 1'($urandom_range(0, 1));
      step("halt.hold", 4'd10, O_HALT);
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst.state", 16'(state), 16'h0);
    check("halt_rst.outs", outs, O_ZERO);
    #3;
    rst_n = 1'b1;
    step("halt_rst.fetch", 4'd1, O_FETCH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/albacore_control.md
Name: albacore_control

Overview:
Multicycle control FSM for the albacore CPU. It sits directly upstream of albacore_datapath and drives every datapath select and enable. It consumes the datapath's opcode, zero and neg outputs and sequences fetch, decode, execute, memory and write-back. It also produces the external memory write strobe and a halt indication.

Parameters:
ALU_ADDR, 4'h8, alu_op code for the effective-address calculation (LD/ST).
ALU_BR, 4'hA, alu_op code for PC + sign-extended branch offset.
ALU_INC_PC, 4'hB, alu_op code for PC + 1.
ALU_PASS_PC, 4'hD, alu_op code that passes PC to the output.
ALU_PASS_A, 4'hE, alu_op code that passes A to the output.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  4  instruction opcode from datapath
zero  in  1  ALU zero flag (combinational, current alu_op)
neg  in  1  ALU negative flag (combinational, current alu_op)
s_addr  out  1  address mux select: 0 = pc, 1 = f
en_inst, en_a, en_b, en_f, en_mdr, en_pc  out  1 each  register enables
alu_op  out  4  ALU operation
s_regfile_din  out  1  regfile write data: 0 = f, 1 = mdr
we_regfile  out  1  regfile write enable
s_regfile_rw  out  1  regfile write address: 1 forces r15
mem_we  out  1  memory write strobe (data = dout, address = addr)
halted  out  1  high in HALT state
state  out  4  current state encoding, for debug and bench

Behaviour:
- Moore FSM. All outputs decode from state only. Any output not listed for a state is 0; alu_op defaults to 4'h0.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 SHL, 6 SHR, 7 LDI, 8 LD, 9 ST, A BR, B BZ, C BN, D JAL, E JR, F QUIT. All 16 opcodes are defined.
- State encodings: START=0, FETCH=1, DECODE=2, EXEC=3, WB_ALU=4, MEM_RD=5, WB_MEM=6, MEM_WR=7, BR_TAKE=8, WB_LINK=9, HALT=10. Codes 11-15 are illegal and go to START on the next clock.
- Reset: rst_n low forces state=START immediately, asynchronously, including mid-instruction.
  - In START every output is 0, including halted and mem_we.
  - The take flag clears to 0.
  - START always goes to FETCH.
- FETCH: s_addr=0, en_inst=1, alu_op=ALU_INC_PC, en_pc=1.
  - Memory read is combinational, so inst captures mem[pc_old] and pc becomes pc_old+1 on the same edge.
  - Next state: DECODE.
- DECODE: en_a=1, en_b=1. Next state: EXEC.
- EXEC, by opcode:
  - 0-7: alu_op=opcode, en_f=1. Next WB_ALU.
  - 8 LD: alu_op=ALU_ADDR, en_f=1. Next MEM_RD.
  - 9 ST: alu_op=ALU_ADDR, en_f=1. Next MEM_WR.
  - A BR: alu_op=ALU_BR, en_pc=1. Next FETCH.
  - B/C BZ/BN: alu_op=ALU_PASS_A. take <= zero (BZ) or neg (BN), registered. Next BR_TAKE if the flag sampled this cycle is 1, else FETCH.
  - D JAL: alu_op=ALU_PASS_PC, en_f=1. Next WB_LINK.
  - E JR: alu_op=ALU_PASS_A, en_pc=1. Next FETCH.
  - F QUIT: no enables. Next HALT.
- WB_ALU: we_regfile=1, s_regfile_din=0. Next FETCH.
- MEM_RD: s_addr=1, en_mdr=1. Next WB_MEM.
- WB_MEM: we_regfile=1, s_regfile_din=1. Next FETCH.
- MEM_WR: s_addr=1, mem_we=1 for exactly one cycle. Next FETCH.
- BR_TAKE: alu_op=ALU_BR, en_pc=1. Next FETCH. The offset is relative to the incremented PC.
- WB_LINK: we_regfile=1, s_regfile_rw=1, s_regfile_din=0, alu_op=ALU_BR, en_pc=1.
  - r15 gets the old pc+1 (held in f) and pc gets the branch target on the same edge.
  - Next FETCH.
- HALT: halted=1. No enables, no mem_we. Stays in HALT until rst_n is asserted.
- Cycles per instruction, FETCH through return to FETCH:
  - 4: ALU ops, LDI, ST, JAL, taken BZ/BN
  - 5: LD
  - 3: BR, JR, not-taken BZ/BN
- Invariants:
  - en_pc and en_inst are never high outside FETCH, EXEC (BR/JR), BR_TAKE and WB_LINK.
  - mem_we is never high together with we_regfile.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC of ADD -> state=0 and all outputs 0 in the same cycle. Release rst_n -> FETCH on the next edge with en_inst=1, en_pc=1, alu_op=4'hB.
- ADD (opcode 0) -> states 1,2,3,4,1. EXEC shows alu_op=0 with en_f=1. WB_ALU shows we_regfile=1, s_regfile_din=0.
- LD (opcode 8) -> states 1,2,3,5,6,1. MEM_RD has s_addr=1, en_mdr=1. WB_MEM has s_regfile_din=1, we=1. ST (opcode 9) -> MEM_WR with mem_we=1 for exactly 1 cycle.
- BZ (opcode B) with zero=1 in EXEC -> BR_TAKE with en_pc=1, alu_op=4'hA. With zero=0 -> FETCH directly. BN behaves the same, using neg.
- JAL (opcode D) -> EXEC alu_op=4'hD, en_f=1, then WB_LINK with s_regfile_rw=1, we=1, en_pc=1 in the same cycle. JR -> EXEC en_pc=1, alu_op=4'hE, 3 cycles total.
- QUIT (opcode F) -> HALT, halted=1, held for 20 cycles with no enables regardless of opcode/zero/neg. rst_n pulse -> START then FETCH.
